// File: rtl/fn_sw.sv
// -----------------------------------------------------------------------------
// fn_sw : function-switch datapath cell
//
// Selects between bitwise AND and bitwise XOR of two operands. The result is
// available combinationally on y, and as a registered, valid-qualified copy on
// y_q with a registered all-zeros flag, so the cell can sit either inside a
// combinational path or at a pipeline stage boundary.
//
// Parameters
//   WIDTH      operand / result width in bits (1..64)
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous assert, active-low reset
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   sel        in   1      function select: 1 = AND, 0 = XOR
//   in_valid   in   1      qualifies a/b/sel for the registered path
//   y          out  WIDTH  combinational result
//   y_q        out  WIDTH  registered result (holds when in_valid is low)
//   y_zero     out  1      registered flag, 1 when y_q is all zeros
//   out_valid  out  1      registered, 1 when y_q holds a fresh result
// -----------------------------------------------------------------------------
module fn_sw #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             y_zero,
    output logic             out_valid
);

    // Bitwise function switch; an unknown select propagates as X in simulation.
    function automatic logic [WIDTH-1:0] f_switch(
        input logic [WIDTH-1:0] fa,
        input logic [WIDTH-1:0] fb,
        input logic             fsel
    );
        return fsel ? (fa & fb) : (fa ^ fb);
    endfunction

    function automatic logic f_is_zero(input logic [WIDTH-1:0] fv);
        return (fv == '0);
    endfunction

    logic [WIDTH-1:0] w_y_p0;
    logic             w_zero_p0;

    logic [WIDTH-1:0] r_y_p1;
    logic             r_zero_p1;
    logic             r_vld_p1;

    assign w_y_p0    = f_switch(a, b, sel);
    assign w_zero_p0 = f_is_zero(w_y_p0);

    // ---- stage p0 -> p1 ----
    // Data registers are reset too: the reset value of y_q/y_zero is visible.
    // While in_valid is low the data holds and only the valid flag drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y_p1    <= '0;
            r_zero_p1 <= 1'b1;
            r_vld_p1  <= 1'b0;
        end else begin
            r_vld_p1 <= in_valid;
            if (in_valid) begin
                r_y_p1    <= w_y_p0;
                r_zero_p1 <= w_zero_p0;
            end
        end
    end

    assign y         = w_y_p0;
    assign y_q       = r_y_p1;
    assign y_zero    = r_zero_p1;
    assign out_valid = r_vld_p1;

endmodule

// File: tb/tb_fn_sw.sv
module tb_fn_sw;

    logic       clk;
    logic       rst_n;

    // 8-bit instance
    logic [7:0] a, b;
    logic       sel, in_valid;
    logic [7:0] y, y_q;
    logic       y_zero, out_valid;

    // 1-bit instance
    logic [0:0] a1, b1;
    logic       sel1, in_valid1;
    logic [0:0] y1, y1_q;
    logic       y1_zero, out_valid1;

    int checks = 0;
    int errors = 0;

    // expected {y_q, y_zero}, pushed when a valid input is driven
    logic [8:0] sb_q[$];
    logic [7:0] exp_q;
    logic       exp_zero;

    fn_sw #(.WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .sel(sel), .in_valid(in_valid),
        .y(y), .y_q(y_q), .y_zero(y_zero), .out_valid(out_valid)
    );

    fn_sw #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .sel(sel1), .in_valid(in_valid1),
        .y(y1), .y_q(y1_q), .y_zero(y1_zero), .out_valid(out_valid1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model(input logic [7:0] ma, input logic [7:0] mb, input logic ms);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            if (ms) r[i] = ma[i] && mb[i];
            else    r[i] = ma[i] != mb[i];
        end
        return r;
    endfunction

    // Called just after a rising edge: drive, check y, clock, check registered path.
    task automatic step(input logic [7:0] ta, input logic [7:0] tb, input logic ts, input logic tv);
        logic [7:0] e;
        logic [8:0] ent;
        a = ta; b = tb; sel = ts; in_valid = tv;
        e = model(ta, tb, ts);
        #1;
        check("y", y, e);
        if (tv) sb_q.push_back({e, (e == 8'h00)});
        @(posedge clk);
        #1;
        if (tv) begin
            if (sb_q.size() == 0) begin
                check("sb_empty", 1, 0);
            end else begin
                ent      = sb_q.pop_front();
                exp_q    = ent[8:1];
                exp_zero = ent[0];
            end
            check("out_valid", out_valid, 1);
        end else begin
            check("out_valid_lo", out_valid, 0);
        end
        check("y_q", y_q, exp_q);
        check("y_zero", y_zero, exp_zero);
    endtask

    logic [2:0] sweep [6];

    initial begin
        rst_n = 1'b1;
        a = 8'h00; b = 8'h00; sel = 1'b0; in_valid = 1'b0;
        a1 = 1'b0; b1 = 1'b0; sel1 = 1'b0; in_valid1 = 1'b0;
        exp_q = 8'h00; exp_zero = 1'b1;

        // async reset with no clock edge
        #1 rst_n = 1'b0;
        #2;
        check("rst_y_q", y_q, 8'h00);
        check("rst_y_zero", y_zero, 1);
        check("rst_out_valid", out_valid, 0);

        // WIDTH=1 combinational sweep: {a, b, sel} -> expected y
        sweep[0] = 3'b000; sweep[1] = 3'b001; sweep[2] = 3'b010;
        sweep[3] = 3'b011; sweep[4] = 3'b110; sweep[5] = 3'b111;
        for (int i = 0; i < 6; i++) begin
            a1 = sweep[i][2]; b1 = sweep[i][1]; sel1 = sweep[i][0];
            #1;
            check($sformatf("w1_y_%0d", i), y1,
                  sweep[i][0] ? (sweep[i][2] & sweep[i][1]) : (sweep[i][2] ^ sweep[i][1]));
        end

        // y follows inputs under reset
        a = 8'hF0; b = 8'h3C; sel = 1'b1;
        #1 check("rst_y_follow", y, 8'h30);

        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // A5 ^ 0F with capture, then AND view
        step(8'hA5, 8'h0F, 1'b0, 1'b1);
        check("aa_y_q", y_q, 8'hAA);
        sel = 1'b1;
        #1 check("and_y", y, 8'h05);
        step(8'hA5, 8'h0F, 1'b0, 1'b1);

        // hold: new operands, in_valid low
        step(8'h12, 8'h34, 1'b0, 1'b0);
        check("hold_y_q", y_q, 8'hAA);

        // zero flag
        step(8'h3C, 8'h3C, 1'b0, 1'b1);
        check("zero_flag", y_zero, 1);

        // async reset mid-cycle while out_valid is high, pending result discarded
        step(8'hFF, 8'h81, 1'b1, 1'b1);
        a = 8'h55; b = 8'hAA; sel = 1'b0; in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_y_q", y_q, 8'h00);
        check("mid_rst_y_zero", y_zero, 1);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_y", y, 8'hFF);
        sb_q.delete();
        exp_q = 8'h00; exp_zero = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("rst_hold_vld", out_valid, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // first edge after reset with valid, then streaming 10 valid cycles
        for (int i = 0; i < 10; i++) begin
            step(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
        end

        // mixed random traffic
        for (int i = 0; i < 20; i++) begin
            step(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fn_sw.md
# fn_sw

Function-switch datapath cell: selects between bitwise AND and bitwise XOR of two operands under a single select line. It provides the result both combinationally and as a registered, valid-qualified output, so it can sit directly in a combinational path or at a pipeline stage boundary. It is a leaf block with no sub-modules.

## Interface
Parameters:
- WIDTH, 1: operand and result width in bits (legal range 1..64).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; deassertion is synchronised by the integrator.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- sel  input  1  function select: 1 = AND, 0 = XOR.
- in_valid  input  1  qualifies a/b/sel for the registered path.
- y  output  WIDTH  combinational result.
- y_q  output  WIDTH  registered result.
- y_zero  output  1  registered flag, 1 when y_q is all zeros.
- out_valid  output  1  registered; 1 when y_q holds a result.

## Operation
- Combinational path: y = sel ? (a & b) : (a ^ b), bitwise across all WIDTH bits. No dependence on clk, rst_n or in_valid.
- If sel is X/Z, y is X in simulation; no X-suppression logic.
- Registered path, on each rising clk edge with rst_n high:
  - in_valid = 1: y_q <= y; y_zero <= (y == 0); out_valid <= 1.
  - in_valid = 0: y_q and y_zero hold their values; out_valid <= 0.
- No back-pressure: the block accepts a new operand set every cycle. The downstream consumer must sample y_q while out_valid is 1.
- Result width equals operand width. No carry and no overflow; the upper bits are never truncated or extended.

## Timing
- y: zero-cycle latency, pure combinational (a, b, sel to y).
- y_q, y_zero, out_valid: one-cycle latency from in_valid sampled high.
- Reset (rst_n low) acts immediately, without waiting for clk:
  - y_q = 0
  - y_zero = 1
  - out_valid = 0
- y keeps following its inputs while reset is held low.
- Reset asserted while a result is pending: out_valid drops immediately and the pending result is discarded.
- First edge after rst_n rises, with in_valid = 1: captures normally.
- Back-to-back in_valid: y_q updates every cycle and out_valid stays 1 continuously.

## Test plan
- Combinational sweep, WIDTH=1, checking y after settling:
  - a=0, b=0, sel=0 -> y=0.
  - a=0, b=0, sel=1 -> y=0.
  - a=0, b=1, sel=0 -> y=1.
  - a=0, b=1, sel=1 -> y=0.
  - a=1, b=1, sel=0 -> y=0.
  - a=1, b=1, sel=1 -> y=1.
- WIDTH=8, sel=0, a=8'hA5, b=8'h0F, in_valid=1:
  - y=8'hAA immediately.
  - Next edge: y_q=8'hAA, y_zero=0, out_valid=1.
  - Then switch to sel=1: y=8'h05.
- Zero flag: WIDTH=8, a=b=8'h3C, sel=0, in_valid=1 -> next edge: y_q=0, y_zero=1, out_valid=1.
- Hold: capture 8'hAA, then drive in_valid=0 with new operands -> y_q stays 8'hAA, out_valid=0, y tracks the new inputs.
- Async reset: with out_valid=1, pull rst_n low mid-cycle -> y_q=0, y_zero=1, out_valid=0 before the next edge.
- Streaming: drive 10 consecutive valid inputs -> out_valid stays high 10 cycles, each y_q matching the prior cycle's y.
